crc_check: RTL and testbench

//  Receive-side counterpart of the parallel CRC generator (crc). Accepts a framed

---
 rtl/crc_check.sv | 155 +++++++++++++++
 tb/tb_crc_check.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_check.sv
`default_nettype none
// ============================================================================
//  Module      : crc_check
//  Description : Receive-side CRC checker. Recomputes the CRC over a framed
//                payload, compares it with the trailing CRC beat and keeps
//                good/bad frame counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_check #(
    parameter int                   CRC_WIDTH  = 8,
    parameter int                   DATA_WIDTH = 8,
    parameter logic [CRC_WIDTH-1:0] POLY       = 8'h07,
    parameter int                   MAX_LEN    = 255,
    parameter int                   CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           din_vld,
    input  logic                           din_sof,
    input  logic                           din_eof,
    input  logic [DATA_WIDTH-1:0]          din,
    input  logic [CRC_WIDTH-1:0]           crc_initial,
    output logic                           chk_done,
    output logic                           chk_ok,
    output logic [CRC_WIDTH-1:0]           crc_calc,
    output logic [$clog2(MAX_LEN+1)-1:0]   frame_len,
    output logic                           len_err,
    output logic                           abort,
    output logic [CNT_WIDTH-1:0]           cnt_ok,
    output logic [CNT_WIDTH-1:0]           cnt_bad
);

    localparam int                c_LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [c_LEN_W-1:0] c_MAX_LEN = c_LEN_W'(MAX_LEN);
    localparam logic [0:0]        c_IDLE  = 1'b0;
    localparam logic [0:0]        c_RUN   = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_next_state;
    logic [CRC_WIDTH-1:0] r_crc;
    logic [c_LEN_W-1:0]   r_len;
    logic                 r_ovf;
    logic                 r_chk_done;
    logic                 r_chk_ok;
    logic [CRC_WIDTH-1:0] r_crc_calc;
    logic [c_LEN_W-1:0]   r_frame_len;
    logic                 r_len_err;
    logic                 r_abort;
    logic [CNT_WIDTH-1:0] r_cnt_ok;
    logic [CNT_WIDTH-1:0] r_cnt_bad;
    logic                 w_start;
    logic                 w_step;
    logic                 w_report;
    logic                 w_zero;
    logic                 w_abort;
    logic                 w_pass;

    // One beat: fold the MSB-aligned data into the register, then shift out DATA_WIDTH bits.
    function automatic logic [CRC_WIDTH-1:0] f_crc_step(
        input logic [CRC_WIDTH-1:0]  crc,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [CRC_WIDTH-1:0] c;
        c = crc ^ data[DATA_WIDTH-1 -: CRC_WIDTH];
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (c[CRC_WIDTH-1]) c = (c << 1) ^ POLY;
            else                c = c << 1;
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (din_vld && din_sof && !din_eof) w_next_state = c_RUN;
            c_RUN:   if (din_vld && din_eof)             w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // A sof restarts the frame in either state; sof together with eof is always a zero-length frame.
    always_comb begin
        w_start  = din_vld && din_sof && !din_eof;
        w_zero   = din_vld && din_sof && din_eof;
        w_step   = 1'b0;
        w_report = 1'b0;
        w_abort  = 1'b0;
        if (r_state == c_RUN) begin
            w_step   = din_vld && !din_sof && !din_eof;
            w_report = din_vld && !din_sof && din_eof;
            w_abort  = din_vld && din_sof;
        end
    end

    assign w_pass = (r_crc == din[CRC_WIDTH-1:0]) && !r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc       <= '0;
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_chk_done  <= 1'b0;
            r_chk_ok    <= 1'b0;
            r_crc_calc  <= '0;
            r_frame_len <= '0;
            r_len_err   <= 1'b0;
            r_abort     <= 1'b0;
            r_cnt_ok    <= '0;
            r_cnt_bad   <= '0;
        end else begin
            r_chk_done <= w_report || w_zero;
            r_abort    <= w_abort;
            if (w_start) begin
                r_crc <= f_crc_step(crc_initial, din);
                r_len <= c_LEN_W'(1);
                r_ovf <= 1'b0;
            end else if (w_step) begin
                r_crc <= f_crc_step(r_crc, din);
                // Length sticks at MAX_LEN; the extra beat is remembered as an overflow.
                if (r_len == c_MAX_LEN) r_ovf <= 1'b1;
                else                    r_len <= r_len + 1'b1;
            end
            if (w_report) begin
                r_crc_calc  <= r_crc;
                r_frame_len <= r_len;
                r_len_err   <= r_ovf;
                r_chk_ok    <= w_pass;
                if (w_pass) r_cnt_ok  <= r_cnt_ok + 1'b1;
                else        r_cnt_bad <= r_cnt_bad + 1'b1;
            end else if (w_zero) begin
                r_crc_calc  <= crc_initial;
                r_frame_len <= '0;
                r_len_err   <= 1'b1;
                r_chk_ok    <= 1'b0;
                r_cnt_bad   <= r_cnt_bad + 1'b1;
            end
        end
    end

    assign chk_done  = r_chk_done;
    assign chk_ok    = r_chk_ok;
    assign crc_calc  = r_crc_calc;
    assign frame_len = r_frame_len;
    assign len_err   = r_len_err;
    assign abort     = r_abort;
    assign cnt_ok    = r_cnt_ok;
    assign cnt_bad   = r_cnt_bad;

endmodule
`default_nettype wire

// File: tb/tb_crc_check.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_crc_check
//  Description : Randomised self-checking bench for crc_check against a
//                bit-serial polynomial-division model of each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_check;

    localparam int             CW      = 8;
    localparam int             DW      = 8;
    localparam int             MAX_LEN = 255;
    localparam int             CNT_W   = 5;
    localparam int             LW      = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0]  POLY    = 8'h07;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din_vld = 1'b0;
    logic          din_sof = 1'b0;
    logic          din_eof = 1'b0;
    logic [DW-1:0] din = '0;
    logic [CW-1:0] crc_initial = '0;
    logic          chk_done;
    logic          chk_ok;
    logic [CW-1:0] crc_calc;
    logic [LW-1:0] frame_len;
    logic          len_err;
    logic          abort;
    logic [CNT_W-1:0] cnt_ok;
    logic [CNT_W-1:0] cnt_bad;

    crc_check #(
        .CRC_WIDTH (CW),
        .DATA_WIDTH(DW),
        .POLY      (POLY),
        .MAX_LEN   (MAX_LEN),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_vld    (din_vld),
        .din_sof    (din_sof),
        .din_eof    (din_eof),
        .din        (din),
        .crc_initial(crc_initial),
        .chk_done   (chk_done),
        .chk_ok     (chk_ok),
        .crc_calc   (crc_calc),
        .frame_len  (frame_len),
        .len_err    (len_err),
        .abort      (abort),
        .cnt_ok     (cnt_ok),
        .cnt_bad    (cnt_bad)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;

    // Reference model state: the payload of the open frame and the expected outputs.
    bit            m_run;
    logic [CW-1:0] m_seed;
    logic [DW-1:0] payload[$];
    bit            exp_done, exp_abort, exp_ok, exp_lerr;
    logic [CW-1:0] exp_crc;
    int            exp_len;
    int            m_cnt_ok, m_cnt_bad;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // CRC as long division of the message bit stream, seed preloaded into the remainder.
    function automatic logic [CW-1:0] ref_crc(input logic [CW-1:0] seed);
        logic [CW-1:0] c;
        logic          fb;
        c = seed;
        foreach (payload[i]) begin
            for (int b = DW - 1; b >= 0; b--) begin
                fb = c[CW-1] ^ payload[i][b];
                c  = {c[CW-2:0], 1'b0};
                if (fb) c = c ^ POLY;
            end
        end
        return c;
    endfunction

    task automatic model_reset();
        m_run = 0; payload.delete();
        exp_done = 0; exp_abort = 0; exp_ok = 0; exp_lerr = 0;
        exp_crc = '0; exp_len = 0; m_cnt_ok = 0; m_cnt_bad = 0;
    endtask

    task automatic model_beat(input logic v, input logic s, input logic e,
                              input logic [DW-1:0] d, input logic [CW-1:0] seed);
        logic [CW-1:0] c;
        exp_done  = 0;
        exp_abort = 0;
        if (!v) return;
        if (s) begin
            if (m_run) exp_abort = 1;
            payload.delete();
            if (e) begin
                exp_done = 1; exp_ok = 0; exp_lerr = 1; exp_len = 0; exp_crc = seed;
                m_cnt_bad = (m_cnt_bad + 1) % (1 << CNT_W);
                m_run = 0;
            end else begin
                m_run = 1; m_seed = seed; payload.push_back(d);
            end
        end else if (m_run) begin
            if (e) begin
                c        = ref_crc(m_seed);
                exp_done = 1;
                exp_crc  = c;
                exp_lerr = payload.size() > MAX_LEN;
                exp_len  = (payload.size() > MAX_LEN) ? MAX_LEN : payload.size();
                exp_ok   = (c == d[CW-1:0]) && !exp_lerr;
                if (exp_ok) m_cnt_ok  = (m_cnt_ok + 1) % (1 << CNT_W);
                else        m_cnt_bad = (m_cnt_bad + 1) % (1 << CNT_W);
                m_run = 0;
            end else begin
                payload.push_back(d);
            end
        end
    endtask

    task automatic check_outputs();
        check("chk_done",  32'(chk_done),  32'(exp_done));
        check("abort",     32'(abort),     32'(exp_abort));
        check("crc_calc",  32'(crc_calc),  32'(exp_crc));
        check("frame_len", 32'(frame_len), 32'(exp_len));
        check("cnt_ok",    32'(cnt_ok),    32'(m_cnt_ok));
        check("cnt_bad",   32'(cnt_bad),   32'(m_cnt_bad));
        if (exp_done) begin
            check("chk_ok",  32'(chk_ok),  32'(exp_ok));
            check("len_err", 32'(len_err), 32'(exp_lerr));
        end
    endtask

    // Each beat first checks the result of the previous clock edge, then drives new inputs.
    task automatic beat(input logic v, input logic s, input logic e,
                        input logic [DW-1:0] d, input logic [CW-1:0] seed);
        @(negedge clk);
        check_outputs();
        din_vld = v; din_sof = s; din_eof = e; din = d; crc_initial = seed;
        model_beat(v, s, e, d, seed);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            beat(1'b0, 1'($urandom), 1'($urandom), DW'($urandom), CW'($urandom));
    endtask

    task automatic send_frame(input logic [CW-1:0] seed, input int n, input bit good);
        logic [CW-1:0] c;
        beat(1'b1, 1'b1, 1'b0, DW'($urandom), seed);
        for (int i = 1; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            beat(1'b1, 1'b0, 1'b0, DW'($urandom), CW'($urandom));
        end
        if ($urandom_range(0, 3) == 0) idle(1);
        c = ref_crc(m_seed);
        if (!good) c = c ^ CW'($urandom_range(1, 255));
        beat(1'b1, 1'b0, 1'b1, DW'(c), CW'($urandom));
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs();
        check("rst_chk_ok",  32'(chk_ok),  32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-beat frame, known CRC
        beat(1'b1, 1'b1, 1'b0, 8'hAA, 8'h00);
        beat(1'b1, 1'b0, 1'b1, 8'h5F, 8'h00);
        idle(1);
        check("t1_crc", 32'(crc_calc), 32'h5F);
        check("t1_ok",  32'(chk_ok),   32'd1);
        check("t1_len", 32'(frame_len), 32'd1);
        check("t1_cnt", 32'(cnt_ok),   32'd1);

        // Two-beat frame, then the same with a corrupted CRC
        beat(1'b1, 1'b1, 1'b0, 8'hAA, 8'h00);
        beat(1'b1, 1'b0, 1'b0, 8'hF0, 8'h00);
        beat(1'b1, 1'b0, 1'b1, 8'h44, 8'h00);
        idle(1);
        check("t2_ok",  32'(chk_ok),    32'd1);
        check("t2_len", 32'(frame_len), 32'd2);
        beat(1'b1, 1'b1, 1'b0, 8'hAA, 8'h00);
        beat(1'b1, 1'b0, 1'b0, 8'hF0, 8'h00);
        beat(1'b1, 1'b0, 1'b1, 8'h45, 8'h00);
        idle(1);
        check("t2_bad_ok",  32'(chk_ok),  32'd0);
        check("t2_bad_cnt", 32'(cnt_bad), 32'd1);

        // Seed continuation, then back-to-back sof
        beat(1'b1, 1'b1, 1'b0, 8'hF0, 8'h5F);
        beat(1'b1, 1'b0, 1'b1, 8'h44, 8'h00);
        beat(1'b1, 1'b1, 1'b0, 8'h12, 8'h33);
        check("t3_ok", 32'(chk_ok), 32'd1);
        beat(1'b1, 1'b0, 1'b1, DW'(ref_crc(m_seed)), 8'h00);
        idle(1);
        check("t3_b2b_ok", 32'(chk_ok), 32'd1);

        // Abort by an unexpected sof
        beat(1'b1, 1'b1, 1'b0, 8'hAA, 8'h00);
        beat(1'b1, 1'b0, 1'b0, 8'hAA, 8'h00);
        beat(1'b1, 1'b1, 1'b0, 8'hF0, 8'h00);
        beat(1'b1, 1'b0, 1'b1, DW'(ref_crc(m_seed)), 8'h00);
        check("t4_abort", 32'(abort),    32'd1);
        check("t4_done",  32'(chk_done), 32'd0);
        idle(1);
        check("t4_ok",  32'(chk_ok),    32'd1);
        check("t4_len", 32'(frame_len), 32'd1);

        // Zero-length frame, in IDLE and after an abort
        beat(1'b1, 1'b1, 1'b1, 8'h00, 8'h3C);
        idle(1);
        check("t5_lerr", 32'(len_err),   32'd1);
        check("t5_ok",   32'(chk_ok),    32'd0);
        check("t5_crc",  32'(crc_calc),  32'h3C);
        check("t5_len",  32'(frame_len), 32'd0);
        beat(1'b1, 1'b1, 1'b0, 8'h77, 8'h00);
        beat(1'b1, 1'b1, 1'b1, 8'h00, 8'hC3);
        idle(1);

        // Length boundaries
        send_frame(CW'($urandom), MAX_LEN, 1'b1);
        idle(1);
        check("t5_max_ok",  32'(chk_ok),    32'd1);
        check("t5_max_len", 32'(frame_len), 32'(MAX_LEN));
        send_frame(CW'($urandom), MAX_LEN + 1, 1'b1);
        idle(1);
        check("t5_ovf_lerr", 32'(len_err),   32'd1);
        check("t5_ovf_len",  32'(frame_len), 32'(MAX_LEN));
        check("t5_ovf_ok",   32'(chk_ok),    32'd0);

        // Reset mid-frame
        beat(1'b1, 1'b1, 1'b0, 8'h5A, 8'h11);
        beat(1'b1, 1'b0, 1'b0, 8'hA5, 8'h00);
        @(negedge clk);
        check_outputs();
        din_vld = 1'b0;
        model_beat(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("t6_rst_ok",   32'(chk_ok),  32'd0);
        check("t6_rst_lerr", 32'(len_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        idle(1);

        // Counter wrap
        while (m_cnt_ok != (1 << CNT_W) - 1)
            send_frame(CW'($urandom), $urandom_range(1, 4), 1'b1);
        send_frame(CW'($urandom), 2, 1'b1);
        idle(1);
        check("t6_wrap", 32'(cnt_ok), 32'd0);

        // Randomised traffic
        for (int f = 0; f < 80; f++) begin
            case ($urandom_range(0, 9))
                7: begin
                    beat(1'b1, 1'b1, 1'b0, DW'($urandom), CW'($urandom));
                    beat(1'b1, 1'b0, 1'b0, DW'($urandom), CW'($urandom));
                    send_frame(CW'($urandom), $urandom_range(1, 8), 1'($urandom));
                end
                8: begin
                    if ($urandom_range(0, 1) == 1)
                        beat(1'b1, 1'b1, 1'b0, DW'($urandom), CW'($urandom));
                    beat(1'b1, 1'b1, 1'b1, DW'($urandom), CW'($urandom));
                end
                9: begin
                    beat(1'b1, 1'b0, 1'($urandom), DW'($urandom), CW'($urandom));
                    idle($urandom_range(0, 2));
                end
                default: send_frame(CW'($urandom), $urandom_range(1, 12), 1'($urandom));
            endcase
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
